// File: rtl/seg7_scan_controller.sv
// Four-digit common-anode seven-segment scan controller.
// Per-frame input snapshot, per-slot dead time, leading-zero blanking.
module seg7_scan_controller #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          slot_end;
    logic          snap;

    logic [15:0]   sh_digits;
    logic [3:0]    sh_dp;
    logic [3:0]    sh_en;
    logic          sh_lz;

    logic [3:0]    zero;
    logic [3:0]    sup;
    logic [3:0]    dark;
    logic [3:0]    nib;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign slot_end = (cnt == LAST);
    assign snap     = slot_end && (digit_sel == 2'd3);
    assign cnt_n    = slot_end ? '0 : cnt + CW'(1);

    // Slot counter and digit index; the index advances on slot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            digit_sel <= 2'd0;
        end else begin
            cnt <= cnt_n;
            if (slot_end) begin
                digit_sel <= digit_sel + 2'd1;
            end
        end
    end

    // Slot FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BLANK;
        end else begin
            state <= state_n;
        end
    end

    // Next state follows the count the next cycle will hold.
    always_comb begin
        state_n = S_DRIVE;
        if (cnt_n < BLANK_END) begin
            state_n = S_BLANK;
        end
    end

    // Shadow copy of the inputs; reloaded during reset and once per frame.
    always_ff @(posedge clk) begin
        if (reset || snap) begin
            sh_digits <= digits;
            sh_dp     <= dp_in;
            sh_en     <= digit_en;
            sh_lz     <= lz_blank;
        end
    end

    // Frame pulse marks the cycle in which the new snapshot is live.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= snap;
        end
    end

    // Leading-zero chain: a disabled digit counts as a zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            zero[i] = (sh_digits[4*i +: 4] == 4'h0) || !sh_en[i];
        end
        sup[3] = sh_lz & zero[3];
        sup[2] = sup[3] & zero[2];
        sup[1] = sup[2] & zero[1];
        sup[0] = 1'b0;
        dark   = ~sh_en | sup;
    end

    // Current nibble for the active slot.
    always_comb begin
        nib = sh_digits[3:0];
        case (digit_sel)
            2'd0:    nib = sh_digits[3:0];
            2'd1:    nib = sh_digits[7:4];
            2'd2:    nib = sh_digits[11:8];
            default: nib = sh_digits[15:12];
        endcase
    end

    // Output decode: blank during dead time and for dark digits.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (state == S_DRIVE) begin
            seg_d = bcd_to_seg(nib);
            if (!dark[digit_sel]) begin
                an_d = ~(4'b0001 << digit_sel);
                dp_d = ~sh_dp[digit_sel];
            end
        end
    end

    // Registered pin drivers, one cycle behind the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: per-frame vector table with
// a scoreboard queue that absorbs the one-cycle output latency.
module tb_seg7_scan_controller;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int NV           = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dp_in;
        logic [3:0]      en;
        logic            lz;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
        logic [3:0]      care;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       care;
    } exp_t;

    localparam exp_t IDLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, care: 1'b1};

    vec_t vecs [NV];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        digits   = v.digits;
        dp_in    = v.dp_in;
        digit_en = v.en;
        lz_blank = v.lz;
    endtask

    function automatic exp_t expect_for(input vec_t v, input int s,
                                        input int c);
        exp_t e;
        if (c < BLANK_CYCLES) begin
            e = IDLE;
        end else begin
            e = '{an: v.an[s], seg: v.seg[s], dp: v.dp[s],
                  care: v.care[s]};
        end
        return e;
    endfunction

    task automatic cycle_check(input vec_t v, input int f, input int k,
                               input bit tick_at0);
        exp_t e;
        check($sformatf("sel f%0d k%0d", f, k), 32'(digit_sel),
              32'(k / CLK_DIV));
        check($sformatf("frame_tick f%0d k%0d", f, k), 32'(frame_tick),
              32'(k == 0 && tick_at0));
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard f%0d k%0d: got empty, expected entry",
                     f, k);
        end else begin
            e = sb.pop_front();
            check($sformatf("an f%0d k%0d", f, k), 32'(an), 32'(e.an));
            check($sformatf("dp f%0d k%0d", f, k), 32'(dp), 32'(e.dp));
            if (e.care) begin
                check($sformatf("seg f%0d k%0d", f, k), 32'(seg),
                      32'(e.seg));
            end
        end
        sb.push_back(expect_for(v, k / CLK_DIV, k % CLK_DIV));
    endtask

    task automatic check_reset(input string tag);
        check({tag, " an"}, 32'(an), 32'hF);
        check({tag, " seg"}, 32'(seg), 32'h7F);
        check({tag, " dp"}, 32'(dp), 32'h1);
        check({tag, " digit_sel"}, 32'(digit_sel), 32'h0);
        check({tag, " frame_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        vecs[0] = '{digits: 16'h1234, dp_in: 4'h0, en: 4'hF, lz: 1'b0,
            an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
            seg: {7'h79, 7'h24, 7'h30, 7'h19},
            dp: 4'hF, care: 4'hF};
        vecs[1] = '{digits: 16'h5678, dp_in: 4'h0, en: 4'hF, lz: 1'b0,
            an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
            seg: {7'h12, 7'h02, 7'h78, 7'h00},
            dp: 4'hF, care: 4'hF};
        vecs[2] = '{digits: 16'h0040, dp_in: 4'h0, en: 4'hF, lz: 1'b1,
            an: {4'b1111, 4'b1111, 4'b1101, 4'b1110},
            seg: {7'h00, 7'h00, 7'h19, 7'h40},
            dp: 4'hF, care: 4'b0011};
        vecs[3] = '{digits: 16'h0000, dp_in: 4'b1110, en: 4'hF, lz: 1'b1,
            an: {4'b1111, 4'b1111, 4'b1111, 4'b1110},
            seg: {7'h00, 7'h00, 7'h00, 7'h40},
            dp: 4'hF, care: 4'b0001};
        vecs[4] = '{digits: 16'h1234, dp_in: 4'b0100, en: 4'b1011, lz: 1'b0,
            an: {4'b0111, 4'b1111, 4'b1101, 4'b1110},
            seg: {7'h79, 7'h00, 7'h30, 7'h19},
            dp: 4'hF, care: 4'b1011};
        vecs[5] = '{digits: 16'h1234, dp_in: 4'b0100, en: 4'hF, lz: 1'b0,
            an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
            seg: {7'h79, 7'h24, 7'h30, 7'h19},
            dp: 4'b1011, care: 4'hF};
        vecs[6] = '{digits: 16'hFA09, dp_in: 4'h0, en: 4'hF, lz: 1'b0,
            an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
            seg: {7'h3F, 7'h3F, 7'h40, 7'h10},
            dp: 4'hF, care: 4'hF};
        vecs[7] = '{digits: 16'h1050, dp_in: 4'h0, en: 4'b0111, lz: 1'b1,
            an: {4'b1111, 4'b1111, 4'b1101, 4'b1110},
            seg: {7'h00, 7'h00, 7'h12, 7'h40},
            dp: 4'hF, care: 4'b0011};

        reset = 1'b1;
        apply(vecs[0]);
        repeat (3) tick();
        check_reset("reset");
        reset = 1'b0;
        sb.push_back(IDLE);

        for (int f = 0; f < NV; f++) begin
            for (int k = 0; k < 4 * CLK_DIV; k++) begin
                cycle_check(vecs[f], f, k, f > 0);
                if (k == 12 && f < NV - 1) begin
                    apply(vecs[f + 1]);
                end
                tick();
            end
        end

        for (int k = 0; k <= 2 * CLK_DIV + 5; k++) begin
            cycle_check(vecs[NV - 1], NV, k, 1'b1);
            if (k < 2 * CLK_DIV + 5) begin
                tick();
            end
        end
        reset = 1'b1;
        tick();
        check_reset("midreset");
        sb.delete();

        reset = 1'b0;
        sb.push_back(IDLE);
        for (int k = 0; k < 4 * CLK_DIV; k++) begin
            cycle_check(vecs[NV - 1], NV + 1, k, 1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes a 4-digit common-anode seven-segment display for the scoreboard.
- Sequences the digit-select count (0→3, wrap to 0) at a programmable refresh rate.
- Inserts an anode-off dead time at each digit change to suppress ghosting.
- Decodes BCD to segments, with per-digit enable and leading-zero suppression; input data is snapshotted once per frame so the display never tears.

Parameters:
- CLK_DIV, 100000: clk cycles per digit slot; legal range ≥ 4.
- BLANK_CYCLES, 1000: dead-time cycles at the start of each slot; legal range 1 ≤ BLANK_CYCLES < CLK_DIV.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- digits  input  16  four BCD nibbles; [3:0]=digit0 (least significant, rightmost) … [15:12]=digit3 (most significant).
- dp_in  input  4  decimal-point request per digit; bit i belongs to digit i; 1 = lit.
- digit_en  input  4  per-digit enable; 0 forces that digit dark.
- lz_blank  input  1  1 = suppress leading zeros.
- an  output  4  anode drives, active-low; bit i = digit i.
- seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- digit_sel  output  2  index of the current slot.
- frame_tick  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, digit_sel=0, frame_tick=0, slot counter cnt=0.
  - While reset is high, the shadow registers load digits, dp_in, digit_en and lz_blank every cycle.
  - The first frame after reset therefore shows the inputs present during the last reset cycle.
- Slot counter:
  - cnt increments 0..CLK_DIV-1 each clk.
  - At cnt==CLK_DIV-1: cnt←0 and digit_sel←digit_sel+1, with 3 wrapping to 0 (2-bit modular).
- Two-state slot FSM:
  - BLANK while cnt<BLANK_CYCLES; DRIVE while cnt≥BLANK_CYCLES.
  - Reset enters BLANK with cnt=0.
- Snapshot:
  - Taken on the cycle with cnt==CLK_DIV-1 and digit_sel==3.
  - Shadow registers capture all four data inputs; frame_tick=1 on the following cycle, for exactly one cycle.
  - Input changes at any other time are invisible until the next snapshot.
- Output registering:
  - an, seg and dp are registered and reflect the (digit_sel, cnt) of the preceding cycle: one cycle of latency.
  - digit_sel is the counter itself, with no added delay.
- BLANK outputs: an=4'b1111, seg=7'b1111111, dp=1.
- DRIVE outputs, for current digit i:
  - Digit dark when shadow digit_en[i]==0, or when leading-zero suppression applies.
  - Dark means an[i]=1 and all other an bits =1, so no anode is active.
  - Otherwise an = ~(1<<i).
  - seg = decode(nibble i); dp = ~dp_in[i] (from the shadow).
- Leading-zero suppression (lz_blank=1):
  - Digit 3 is suppressed if nibble3==0.
  - Digit 2 is suppressed if nibble3==0 and nibble2==0.
  - Digit 1 is suppressed if nibbles 3..1 are all 0.
  - Digit 0 is never suppressed.
  - Disabled digits (digit_en=0) count as zero for suppression purposes.
  - A suppressed digit also suppresses its dp.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10–15 display a dash: 0111111.
- Never more than one an bit is low in any cycle.
- Reset mid-slot takes effect on the next edge; outputs return to reset values with no partial slot completion.

Test Plan:
- Use CLK_DIV=8 and BLANK_CYCLES=2 for all cases.
- Reset and sequence:
  - Stimulus: hold reset 3 cycles with digits=16'h1234, digit_en=4'hF, lz_blank=0; release.
  - Required: digit_sel steps 0,1,2,3,0 every 8 cycles.
  - Required: an=1111 for 2 cycles, then 1110, 1101, 1011, 0111 for 6 cycles each.
  - Required: seg shows 4, 3, 2, 1 in slots 0–3 respectively.
- Snapshot:
  - Stimulus: change digits to 16'h5678 mid-frame.
  - Required: display unchanged until after frame_tick pulses (cycle after cnt=7, sel=3); next frame shows 8, 7, 6, 5.
- Leading zeros:
  - Stimulus: digits=16'h0040, lz_blank=1.
  - Required: slots 3 and 2 have an=1111 throughout; slot 1 shows 4; slot 0 shows 0.
  - Stimulus: repeat with digits=16'h0000.
  - Required: only digit 0 lit, showing 0.
- Enable and dp:
  - Stimulus: digit_en=4'b1011, dp_in=4'b0100.
  - Required: slot 2 dark with dp=1 across the whole slot.
  - Stimulus: digit_en=4'hF.
  - Required: slot 2 has dp=0.
- Non-BCD:
  - Stimulus: digits=16'hFA09.
  - Required: slots 3 and 2 show seg=0111111; slot 1 shows 0; slot 0 shows 9.
- Mid-slot reset:
  - Stimulus: assert reset at cnt=5, sel=2.
  - Required: next cycle an=1111, seg=1111111, digit_sel=0, frame_tick=0.
